control_sequencer: RTL and testbench



---
 rtl/control_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit for the 32-bit RISC datapath.
// Strobes decode from the registered step; the opcode is captured in T3 for later steps.
//
// state   | meaning
// RESET   | held by clr, all strobes low, run low
// T0      | fetch: PC -> MAR, PC+1 into Z
// T1      | fetch: Z -> PC, memory read into MDR
// T2      | fetch: MDR -> IR
// T3..T7  | execute steps, content depends on instruction class
// HALT    | illegal opcode seen, waits for clr
module control_sequencer (
    input  logic       clk,
    input  logic       clr,
    input  logic [4:0] ir_opcode,
    output logic       pc_out,
    output logic       zlo_out,
    output logic       zhi_out,
    output logic       mdr_out,
    output logic       c_out,
    output logic       mar_enable,
    output logic       z_enable,
    output logic       pc_enable,
    output logic       mdr_enable,
    output logic       ir_enable,
    output logic       y_enable,
    output logic       hi_enable,
    output logic       lo_enable,
    output logic       pc_increment,
    output logic       read,
    output logic       write,
    output logic       gra,
    output logic       grb,
    output logic       grc,
    output logic       r_in,
    output logic       r_out,
    output logic       ba_out,
    output logic [4:0] op_code,
    output logic       run,
    output logic [3:0] step
);

    localparam logic [3:0] S_RESET = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_T4    = 4'd5;
    localparam logic [3:0] S_T5    = 4'd6;
    localparam logic [3:0] S_T6    = 4'd7;
    localparam logic [3:0] S_T7    = 4'd8;
    localparam logic [3:0] S_HALT  = 4'd9;

    localparam logic [4:0] OP_ADD  = 5'b00011;

    logic [3:0] state_q, state_d;
    logic [4:0] opc_q, opc_d;
    logic [4:0] cur_op;
    logic       is_ld, is_ldi, is_st, is_alu, is_imm, is_md, is_nn, is_ill;

    // In T3 the IR has just loaded, so decode live; afterwards use the captured copy.
    always_comb begin
        cur_op = (state_q == S_T3) ? ir_opcode : opc_q;
        is_ld  = (cur_op == 5'd0);
        is_ldi = (cur_op == 5'd1);
        is_st  = (cur_op == 5'd2);
        is_alu = (cur_op >= 5'd3)  && (cur_op <= 5'd11);
        is_imm = (cur_op >= 5'd12) && (cur_op <= 5'd14);
        is_md  = (cur_op == 5'd15) || (cur_op == 5'd16);
        is_nn  = (cur_op == 5'd17) || (cur_op == 5'd18);
        is_ill = (cur_op > 5'd18);
    end

    always_comb begin
        opc_d   = (state_q == S_T3) ? ir_opcode : opc_q;
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = is_ill ? S_HALT : S_T4;
            S_T4:    state_d = is_nn ? S_T0 : S_T5;
            S_T5:    state_d = (is_alu || is_imm || is_ldi) ? S_T0 : S_T6;
            S_T6:    state_d = is_md ? S_T0 : S_T7;
            S_T7:    state_d = S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_RESET;
            opc_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    always_comb begin
        pc_out       = 1'b0;
        zlo_out      = 1'b0;
        zhi_out      = 1'b0;
        mdr_out      = 1'b0;
        c_out        = 1'b0;
        mar_enable   = 1'b0;
        z_enable     = 1'b0;
        pc_enable    = 1'b0;
        mdr_enable   = 1'b0;
        ir_enable    = 1'b0;
        y_enable     = 1'b0;
        hi_enable    = 1'b0;
        lo_enable    = 1'b0;
        pc_increment = 1'b0;
        read         = 1'b0;
        write        = 1'b0;
        gra          = 1'b0;
        grb          = 1'b0;
        grc          = 1'b0;
        r_in         = 1'b0;
        r_out        = 1'b0;
        ba_out       = 1'b0;
        op_code      = 5'd0;
        run          = (state_q >= S_T0) && (state_q <= S_T7);
        step         = run ? (state_q - 4'd1) : 4'd0;
        case (state_q)
            S_T0: begin
                pc_out       = 1'b1;
                mar_enable   = 1'b1;
                pc_increment = 1'b1;
                z_enable     = 1'b1;
                op_code      = OP_ADD;
            end
            S_T1: begin
                zlo_out    = 1'b1;
                pc_enable  = 1'b1;
                read       = 1'b1;
                mdr_enable = 1'b1;
            end
            S_T2: begin
                mdr_out   = 1'b1;
                ir_enable = 1'b1;
            end
            S_T3: begin
                if (is_alu || is_imm) begin
                    grb      = 1'b1;
                    r_out    = 1'b1;
                    y_enable = 1'b1;
                end else if (is_nn) begin
                    grb      = 1'b1;
                    r_out    = 1'b1;
                    op_code  = cur_op;
                    z_enable = 1'b1;
                end else if (is_md) begin
                    gra      = 1'b1;
                    r_out    = 1'b1;
                    y_enable = 1'b1;
                end else if (is_ld || is_ldi || is_st) begin
                    grb      = 1'b1;
                    ba_out   = 1'b1;
                    y_enable = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu || is_md) begin
                    grc      = is_alu;
                    grb      = is_md;
                    r_out    = 1'b1;
                    op_code  = cur_op;
                    z_enable = 1'b1;
                end else if (is_imm) begin
                    c_out    = 1'b1;
                    op_code  = cur_op;
                    z_enable = 1'b1;
                end else if (is_nn) begin
                    zlo_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = 1'b1;
                end else begin
                    c_out    = 1'b1;
                    op_code  = OP_ADD;
                    z_enable = 1'b1;
                end
            end
            S_T5: begin
                zlo_out = 1'b1;
                if (is_alu || is_imm || is_ldi) begin
                    gra  = 1'b1;
                    r_in = 1'b1;
                end else if (is_md) begin
                    lo_enable = 1'b1;
                end else begin
                    mar_enable = 1'b1;
                end
            end
            S_T6: begin
                if (is_md) begin
                    zhi_out   = 1'b1;
                    hi_enable = 1'b1;
                end else if (is_ld) begin
                    read       = 1'b1;
                    mdr_enable = 1'b1;
                end else begin
                    gra        = 1'b1;
                    r_out      = 1'b1;
                    mdr_enable = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    mdr_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = 1'b1;
                end else begin
                    write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected strobe vectors are
// queued by the driver from an instruction-class table and checked by a monitor.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [4:0] ir_opcode = 5'd0;
    logic pc_out, zlo_out, zhi_out, mdr_out, c_out;
    logic mar_enable, z_enable, pc_enable, mdr_enable, ir_enable, y_enable, hi_enable, lo_enable;
    logic pc_increment, read, write, gra, grb, grc, r_in, r_out, ba_out, run;
    logic [4:0] op_code;
    logic [3:0] step;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir_opcode(ir_opcode),
        .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .mdr_out(mdr_out), .c_out(c_out),
        .mar_enable(mar_enable), .z_enable(z_enable), .pc_enable(pc_enable), .mdr_enable(mdr_enable),
        .ir_enable(ir_enable), .y_enable(y_enable), .hi_enable(hi_enable), .lo_enable(lo_enable),
        .pc_increment(pc_increment), .read(read), .write(write),
        .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
        .op_code(op_code), .run(run), .step(step)
    );

    localparam logic [21:0] PCO  = 22'd1 << 0;
    localparam logic [21:0] ZLO  = 22'd1 << 1;
    localparam logic [21:0] ZHI  = 22'd1 << 2;
    localparam logic [21:0] MDRO = 22'd1 << 3;
    localparam logic [21:0] CO   = 22'd1 << 4;
    localparam logic [21:0] MAR  = 22'd1 << 5;
    localparam logic [21:0] ZEN  = 22'd1 << 6;
    localparam logic [21:0] PCEN = 22'd1 << 7;
    localparam logic [21:0] MDRE = 22'd1 << 8;
    localparam logic [21:0] IREN = 22'd1 << 9;
    localparam logic [21:0] YEN  = 22'd1 << 10;
    localparam logic [21:0] HIEN = 22'd1 << 11;
    localparam logic [21:0] LOEN = 22'd1 << 12;
    localparam logic [21:0] PCIN = 22'd1 << 13;
    localparam logic [21:0] RD   = 22'd1 << 14;
    localparam logic [21:0] WR   = 22'd1 << 15;
    localparam logic [21:0] GRA  = 22'd1 << 16;
    localparam logic [21:0] GRB  = 22'd1 << 17;
    localparam logic [21:0] GRC  = 22'd1 << 18;
    localparam logic [21:0] RIN  = 22'd1 << 19;
    localparam logic [21:0] ROUT = 22'd1 << 20;
    localparam logic [21:0] BAO  = 22'd1 << 21;
    localparam logic [4:0]  ADD  = 5'b00011;

    logic [31:0] exp_q[$];
    logic [31:0] model_q[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [31:0] actual_vec();
        return {step, run, op_code, ba_out, r_out, r_in, grc, grb, gra, write, read,
                pc_increment, lo_enable, hi_enable, y_enable, ir_enable, mdr_enable,
                pc_enable, z_enable, mar_enable, c_out, mdr_out, zhi_out, zlo_out, pc_out};
    endfunction

    function automatic void add(input logic [21:0] m, input logic [4:0] opc);
        logic [3:0] s;
        s = 4'(model_q.size());
        model_q.push_back({s, 1'b1, opc, m});
    endfunction

    // Reference: one entry per cycle of the instruction, fetch then class body.
    function automatic void build_seq(input logic [4:0] op);
        int o;
        o = int'(op);
        model_q.delete();
        add(PCO | MAR | PCIN | ZEN, ADD);
        add(ZLO | PCEN | RD | MDRE, 5'd0);
        add(MDRO | IREN, 5'd0);
        if (o > 18) begin
            add(22'd0, 5'd0);
        end else if (o <= 2) begin
            add(GRB | BAO | YEN, 5'd0);
            add(CO | ZEN, ADD);
            if (o == 1) add(ZLO | GRA | RIN, 5'd0);
            else begin
                add(ZLO | MAR, 5'd0);
                if (o == 0) begin
                    add(RD | MDRE, 5'd0);
                    add(MDRO | GRA | RIN, 5'd0);
                end else begin
                    add(GRA | ROUT | MDRE, 5'd0);
                    add(WR, 5'd0);
                end
            end
        end else if (o <= 11) begin
            add(GRB | ROUT | YEN, 5'd0);
            add(GRC | ROUT | ZEN, op);
            add(ZLO | GRA | RIN, 5'd0);
        end else if (o <= 14) begin
            add(GRB | ROUT | YEN, 5'd0);
            add(CO | ZEN, op);
            add(ZLO | GRA | RIN, 5'd0);
        end else if (o <= 16) begin
            add(GRA | ROUT | YEN, 5'd0);
            add(GRB | ROUT | ZEN, op);
            add(ZLO | LOEN, 5'd0);
            add(ZHI | HIEN, 5'd0);
        end else begin
            add(GRB | ROUT | ZEN, op);
            add(ZLO | GRA | RIN, 5'd0);
        end
    endfunction

    task automatic hold_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            exp_q.push_back(32'd0);
            clr = (k < n - 1);
        end
    endtask

    task automatic run_instr(input logic [4:0] op, input int abort_at);
        build_seq(op);
        for (int i = 0; i < model_q.size(); i++) begin
            @(posedge clk); #1;
            ir_opcode = (i < 3) ? 5'($urandom) : op;
            exp_q.push_back(model_q[i]);
            if (i == abort_at) begin
                clr = 1'b1;
                break;
            end
        end
    endtask

    task automatic halt_then_recover(input logic [4:0] op);
        run_instr(op, -1);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            ir_opcode = 5'($urandom);
            exp_q.push_back(32'd0);
            if (k == 19) clr = 1'b1;
        end
        hold_reset(1);
    endtask

    always @(negedge clk) begin
        logic [31:0] e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = actual_vec();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL strobes t=%0t: actual=%h required=%h", $time, a, e);
            end
            checks++;
            if ($countones({pc_out, zlo_out, zhi_out, mdr_out, c_out}) > 1) begin
                failures++;
                $display("FAIL bus_onehot t=%0t: actual drivers=%b required at most one",
                         $time, {pc_out, zlo_out, zhi_out, mdr_out, c_out});
            end
        end
    end

    initial begin
        hold_reset(3);
        run_instr(5'b00100, -1);
        run_instr(5'b10000, -1);
        run_instr(5'b00000, -1);
        run_instr(5'b00010, -1);
        run_instr(5'b10001, -1);
        for (int n = 0; n < 40; n++) run_instr(5'($urandom_range(0, 18)), -1);
        run_instr(5'b00011, 4);
        hold_reset(2);
        run_instr(5'b01111, -1);
        halt_then_recover(5'b11111);
        run_instr(5'b01100, -1);
        halt_then_recover(5'($urandom_range(19, 30)));
        for (int n = 0; n < 20; n++) run_instr(5'($urandom_range(0, 18)), -1);
        for (int w = 0; w < 5 && exp_q.size() != 0; w++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: actual pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
